// File: rtl/branch_unit_bht.sv
// Branch resolution unit: bimodal 2-bit BHT lookup at fetch, RV32I condition evaluation at
// execute, registered resolve/mispredict result, BHT training and saturating statistics.
module branch_unit_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int PC_LSB      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_flush,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_a,
  input  logic [XLEN-1:0]  ex_b,
  input  logic [2:0]       ex_comp_ctrl,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // RV32I funct3 encodings of the branch comparisons.
  typedef enum logic [2:0] {
    COMP_EQ  = 3'b000,
    COMP_NE  = 3'b001,
    COMP_LT  = 3'b100,
    COMP_GE  = 3'b101,
    COMP_LTU = 3'b110,
    COMP_GEU = 3'b111
  } comp_e;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] f_idx, ex_idx;
  logic             acc, train, cond, taken, mispred;
  logic [1:0]       ctr_cur;
  logic             unused_pc;

  assign f_idx  = f_pc[PC_LSB +: IDX_W];
  assign ex_idx = ex_pc[PC_LSB +: IDX_W];
  assign unused_pc = ^{f_pc, ex_pc};

  // Lookup sees the pre-edge table; no bypass of a same-cycle training write.
  assign f_pred_taken = bht_q[f_idx][1];

  assign acc     = ex_valid & ~ex_flush;
  assign train   = acc & ex_branch & ~ex_jump;
  assign taken   = ex_jump | (ex_branch & cond);
  assign mispred = taken ^ ex_pred_taken;
  assign ctr_cur = bht_q[ex_idx];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cond = 1'b0;
    case (comp_e'(ex_comp_ctrl))
      COMP_EQ:  cond = (ex_a == ex_b);
      COMP_NE:  cond = (ex_a != ex_b);
      COMP_LT:  cond = ($signed(ex_a) <  $signed(ex_b));
      COMP_GE:  cond = ($signed(ex_a) >= $signed(ex_b));
      COMP_LTU: cond = (ex_a <  ex_b);
      COMP_GEU: cond = (ex_a >= ex_b);
      default:  cond = 1'b0;
    endcase
  end

  always_comb begin
    bht_d = bht_q;
    if (train) begin
      if (taken && ctr_cur != 2'b11)
        bht_d[ex_idx] = ctr_cur + 2'd1;
      else if (!taken && ctr_cur != 2'b00)
        bht_d[ex_idx] = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    res_valid_d      = acc;
    res_taken_d      = acc & taken;
    res_mispredict_d = acc & mispred;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;
    if (train && branch_cnt_q != {CNT_W{1'b1}})
      branch_cnt_d = branch_cnt_q + 1'b1;
    if (train && mispred && mispred_cnt_q != {CNT_W{1'b1}})
      mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  // NOTE: the BHT is reset entry by entry to weak not-taken, so it maps to flops rather
  // than a RAM macro; predictions must be defined from the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed bench for branch_unit_bht: a default instance plus a CNT_W=4 instance that
// shares all stimulus, used to observe counter saturation.
module tb_branch_unit_bht;

  localparam logic [2:0] C_EQ  = 3'b000;
  localparam logic [2:0] C_NE  = 3'b001;
  localparam logic [2:0] C_BAD = 3'b010;
  localparam logic [2:0] C_LT  = 3'b100;
  localparam logic [2:0] C_GE  = 3'b101;
  localparam logic [2:0] C_LTU = 3'b110;
  localparam logic [2:0] C_GEU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        f_pred_taken, s_f_pred_taken;
  logic        ex_valid, ex_flush, ex_branch, ex_jump, ex_pred_taken;
  logic [31:0] ex_pc, ex_a, ex_b;
  logic [2:0]  ex_comp_ctrl;
  logic        res_valid, res_taken, res_mispredict;
  logic        s_res_valid, s_res_taken, s_res_mispredict;
  logic [15:0] branch_cnt, mispred_cnt;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_unit_bht dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_comp_ctrl(ex_comp_ctrl), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_unit_bht #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(s_f_pred_taken),
    .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_comp_ctrl(ex_comp_ctrl), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_pred_taken(ex_pred_taken), .res_valid(s_res_valid), .res_taken(s_res_taken),
    .res_mispredict(s_res_mispredict), .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one execute-stage instruction and let it cross one rising edge.
  task automatic issue(input logic valid, input logic flush, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                       input logic br, input logic jmp, input logic pred);
    ex_valid = valid; ex_flush = flush; ex_pc = pc; ex_a = a; ex_b = b;
    ex_comp_ctrl = ctrl; ex_branch = br; ex_jump = jmp; ex_pred_taken = pred;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_flush = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic v, input logic t, input logic m);
    check({tag, ".valid"}, {31'd0, res_valid}, {31'd0, v});
    check({tag, ".taken"}, {31'd0, res_taken}, {31'd0, t});
    check({tag, ".mispred"}, {31'd0, res_mispredict}, {31'd0, m});
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    f_pc = pc; #1;
    check(tag, {31'd0, f_pred_taken}, {31'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; f_pc = 32'h40;
    ex_valid = 0; ex_flush = 0; ex_pc = 0; ex_a = 0; ex_b = 0;
    ex_comp_ctrl = C_EQ; ex_branch = 0; ex_jump = 0; ex_pred_taken = 0;
    #12;
    check("rst.f_pred", {31'd0, f_pred_taken}, 32'd0);
    check_res("rst", 0, 0, 0);
    check("rst.branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check("rst.mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Two back-to-back taken BEQs at 0x40 carried as not-taken: 01 -> 10 -> 11.
    issue(1, 0, 32'h40, 32'd5, 32'd5, C_EQ, 1, 0, 0);
    check_res("beq1", 1, 1, 1);
    check_pred("beq1.f_pred", 32'h40, 1);
    issue(1, 0, 32'h40, 32'd5, 32'd5, C_EQ, 1, 0, 0);
    check_res("beq2", 1, 1, 1);
    check("beq2.branch_cnt", {16'd0, branch_cnt}, 32'd2);
    check("beq2.mispred_cnt", {16'd0, mispred_cnt}, 32'd2);
    // Strong-taken: one not-taken outcome leaves the prediction taken (11 -> 10).
    issue(1, 0, 32'h40, 32'd5, 32'd6, C_EQ, 1, 0, 0);
    check_res("beq_nt", 1, 0, 0);
    check_pred("strong.f_pred", 32'h40, 1);
    check_pred("alias.f_pred", 32'h140, 1);
    check("beq_nt.branch_cnt", {16'd0, branch_cnt}, 32'd3);

    issue(1, 0, 32'h80, 32'hFFFF_FFFF, 32'd1, C_LT, 1, 0, 1);
    check_res("blt", 1, 1, 0);
    check_pred("blt.f_pred", 32'h80, 1);
    issue(1, 0, 32'h84, 32'hFFFF_FFFF, 32'd1, C_LTU, 1, 0, 1);
    check_res("bltu", 1, 0, 1);
    issue(1, 0, 32'h88, 32'h8000_0000, 32'd0, C_GE, 1, 0, 0);
    check_res("bge", 1, 0, 0);
    issue(1, 0, 32'h8C, 32'h8000_0000, 32'd0, C_GEU, 1, 0, 0);
    check_res("bgeu", 1, 1, 1);
    issue(1, 0, 32'h90, 32'd1, 32'd2, C_NE, 1, 0, 1);
    check_res("bne", 1, 1, 0);
    check("bne.branch_cnt", {16'd0, branch_cnt}, 32'd8);
    check("bne.mispred_cnt", {16'd0, mispred_cnt}, 32'd4);

    // JAL at a fresh index: resolved taken/mispredicted, but no training or count.
    issue(1, 0, 32'hC0, 32'd0, 32'd0, C_EQ, 0, 1, 0);
    check_res("jal", 1, 1, 1);
    check_pred("jal.f_pred", 32'hC0, 0);
    check("jal.branch_cnt", {16'd0, branch_cnt}, 32'd8);
    check("jal.mispred_cnt", {16'd0, mispred_cnt}, 32'd4);

    issue(1, 1, 32'hC0, 32'd1, 32'd2, C_NE, 1, 0, 0);
    check_res("flush", 0, 0, 0);
    check_pred("flush.f_pred", 32'hC0, 0);
    check("flush.branch_cnt", {16'd0, branch_cnt}, 32'd8);
    check("flush.mispred_cnt", {16'd0, mispred_cnt}, 32'd4);

    issue(1, 0, 32'hD0, 32'd3, 32'd3, C_BAD, 1, 0, 1);
    check_res("badctrl", 1, 0, 1);
    check("badctrl.branch_cnt", {16'd0, branch_cnt}, 32'd9);
    issue(0, 0, 32'h40, 32'd5, 32'd5, C_EQ, 1, 0, 0);
    check_res("idle", 0, 0, 0);

    // Reset while a result is visible, with a valid instruction pending on the inputs.
    issue(1, 0, 32'h40, 32'd5, 32'd5, C_EQ, 1, 0, 0);
    check_res("pre_rst", 1, 1, 1);
    ex_valid = 1'b1;
    rst_n = 1'b0; #1;
    check_res("mid_rst", 0, 0, 0);
    check("mid_rst.branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check_pred("mid_rst.f_pred", 32'h40, 0);
    ex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_res("post_rst", 0, 0, 0);

    // Saturation: 20 mispredicted branches on both instances.
    for (int i = 0; i < 15; i++) issue(1, 0, 32'h40, 32'd7, 32'd7, C_EQ, 1, 0, 0);
    check("sat15.s_branch_cnt", {28'd0, s_branch_cnt}, 32'd15);
    for (int i = 0; i < 5; i++) issue(1, 0, 32'h40, 32'd7, 32'd7, C_EQ, 1, 0, 0);
    check("sat20.s_branch_cnt", {28'd0, s_branch_cnt}, 32'd15);
    check("sat20.s_mispred_cnt", {28'd0, s_mispred_cnt}, 32'd15);
    check("sat20.branch_cnt", {16'd0, branch_cnt}, 32'd20);
    check("sat20.mispred_cnt", {16'd0, mispred_cnt}, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
